// File: rtl/ls_mem_bridge.sv
// Memory-side bridge: serialises mem-stage load/store index requests onto one backing-memory
// request/response port, one transaction at a time, with a response timeout and sticky error.
module ls_mem_bridge #(
    parameter int RESULT_WIDTH   = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clock,
    input  logic                    reset_n,

    input  logic                    opload_index_valid,
    output logic                    opload_index_ready,
    input  logic [RESULT_WIDTH-1:0] opload_index,
    output logic                    opload_operation_done,
    output logic [RESULT_WIDTH-1:0] opload_read_data,

    input  logic                    opstore_index_valid,
    output logic                    opstore_index_ready,
    input  logic [RESULT_WIDTH-1:0] opstore_index,
    input  logic [RESULT_WIDTH-1:0] opstore_write_data,
    input  logic [63:0]             opstore_write_mask,
    output logic                    opstore_operation_done,

    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_write,
    output logic [RESULT_WIDTH-1:0] mem_req_index,
    output logic [RESULT_WIDTH-1:0] mem_req_wdata,
    output logic [63:0]             mem_req_wmask,
    input  logic                    mem_resp_valid,
    input  logic [RESULT_WIDTH-1:0] mem_resp_rdata,

    output logic                    bus_error
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    is_write_q, is_write_d;
    logic [RESULT_WIDTH-1:0] index_q, index_d;
    logic [RESULT_WIDTH-1:0] wdata_q, wdata_d;
    logic [63:0]             wmask_q, wmask_d;
    logic [RESULT_WIDTH-1:0] read_data_q, read_data_d;
    logic                    bus_error_q, bus_error_d;
    logic [CNT_W-1:0]        timeout_cnt_q, timeout_cnt_d;

    logic load_fire;
    logic store_fire;
    logic timeout_hit;

    // Load wins a same-cycle tie, so the store is only taken when no load is offered.
    assign load_fire   = (state_q == IDLE) && opload_index_valid;
    assign store_fire  = (state_q == IDLE) && !opload_index_valid && opstore_index_valid;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (timeout_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (load_fire || store_fire) state_d = ISSUE;
            ISSUE:     if (mem_req_ready) state_d = WAIT_RESP;
            WAIT_RESP: if (mem_resp_valid || timeout_hit) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Readies are gated by reset_n so every output reads 0 while reset is held.
    always_comb begin
        opload_index_ready     = 1'b0;
        opstore_index_ready    = 1'b0;
        mem_req_valid          = 1'b0;
        opload_operation_done  = 1'b0;
        opstore_operation_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                opload_index_ready  = reset_n;
                opstore_index_ready = reset_n & ~opload_index_valid;
            end
            ISSUE: mem_req_valid = 1'b1;
            DONE: begin
                opload_operation_done  = ~is_write_q;
                opstore_operation_done = is_write_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        is_write_d    = is_write_q;
        index_d       = index_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        read_data_d   = read_data_q;
        bus_error_d   = bus_error_q;
        timeout_cnt_d = '0;
        unique case (state_q)
            IDLE: begin
                if (load_fire) begin
                    is_write_d = 1'b0;
                    index_d    = opload_index;
                    wdata_d    = '0;
                    wmask_d    = '0;
                end else if (store_fire) begin
                    is_write_d = 1'b1;
                    index_d    = opstore_index;
                    wdata_d    = opstore_write_data;
                    wmask_d    = opstore_write_mask;
                end
            end
            WAIT_RESP: begin
                timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
                if (mem_resp_valid) begin
                    if (!is_write_q) read_data_d = mem_resp_rdata;
                end else if (timeout_hit) begin
                    bus_error_d = 1'b1;
                    if (!is_write_q) read_data_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            is_write_q    <= 1'b0;
            index_q       <= '0;
            wdata_q       <= '0;
            wmask_q       <= '0;
            read_data_q   <= '0;
            bus_error_q   <= 1'b0;
            timeout_cnt_q <= '0;
        end else begin
            is_write_q    <= is_write_d;
            index_q       <= index_d;
            wdata_q       <= wdata_d;
            wmask_q       <= wmask_d;
            read_data_q   <= read_data_d;
            bus_error_q   <= bus_error_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign mem_req_write    = is_write_q;
    assign mem_req_index    = index_q;
    assign mem_req_wdata    = wdata_q;
    assign mem_req_wmask    = wmask_q;
    assign opload_read_data = read_data_q;
    assign bus_error        = bus_error_q;

endmodule

// File: tb/tb_ls_mem_bridge.sv
// Randomised scoreboard bench for ls_mem_bridge: a driver predicts completions from a memory
// model, a responder plays the backing memory, and a monitor checks every done pulse.
module tb_ls_mem_bridge;

    localparam int W   = 64;
    localparam int TMO = 8;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         opload_index_valid = 1'b0;
    logic         opload_index_ready;
    logic [W-1:0] opload_index = '0;
    logic         opload_operation_done;
    logic [W-1:0] opload_read_data;
    logic         opstore_index_valid = 1'b0;
    logic         opstore_index_ready;
    logic [W-1:0] opstore_index = '0;
    logic [W-1:0] opstore_write_data = '0;
    logic [63:0]  opstore_write_mask = '0;
    logic         opstore_operation_done;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_write;
    logic [W-1:0] mem_req_index;
    logic [W-1:0] mem_req_wdata;
    logic [63:0]  mem_req_wmask;
    logic         mem_resp_valid;
    logic [W-1:0] mem_resp_rdata;
    logic         bus_error;

    ls_mem_bridge #(.RESULT_WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset_n(reset_n),
        .opload_index_valid(opload_index_valid), .opload_index_ready(opload_index_ready),
        .opload_index(opload_index), .opload_operation_done(opload_operation_done),
        .opload_read_data(opload_read_data),
        .opstore_index_valid(opstore_index_valid), .opstore_index_ready(opstore_index_ready),
        .opstore_index(opstore_index), .opstore_write_data(opstore_write_data),
        .opstore_write_mask(opstore_write_mask), .opstore_operation_done(opstore_operation_done),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_index(mem_req_index),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    int cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    typedef struct {
        bit           write;
        logic [W-1:0] idx;
        logic [W-1:0] wdata;
        logic [63:0]  mask;
        int           readyDelay;
        bit           respond;
        int           respDelay;
    } req_t;

    typedef struct {
        bit           isLoad;
        logic [W-1:0] rdata;
        bit           err;
        int           doneCycle;
    } exp_t;

    req_t         planQ[$];
    exp_t         expQ[$];
    logic [W-1:0] refMem [logic [W-1:0]];
    logic [W-1:0] bkMem  [logic [W-1:0]];
    bit           expErr = 1'b0;
    bit           respBusy = 1'b0;
    int           vectors = 0;
    int           miscompares = 0;

    function automatic logic [W-1:0] defaultWord(input logic [W-1:0] idx);
        return {32'hC0DE_0000 ^ idx[31:0], idx[31:0] * 32'h9E37_79B1};
    endfunction

    function automatic req_t mkReq(input bit write, input logic [W-1:0] idx,
                                   input logic [W-1:0] wdata, input logic [63:0] mask,
                                   input int rd, input bit respond, input int rsd);
        req_t r;
        r.write = write; r.idx = idx; r.wdata = wdata; r.mask = mask;
        r.readyDelay = rd; r.respond = respond; r.respDelay = rsd;
        return r;
    endfunction

    function automatic req_t randReq(input bit write);
        logic [63:0] m;
        m = ($urandom_range(0, 3) == 0) ? '1 : {$urandom, $urandom};
        return mkReq(write, 64'($urandom_range(0, 15)),
                     write ? {$urandom, $urandom} : '0, write ? m : '0,
                     $urandom_range(0, 3), ($urandom_range(0, 11) != 0), $urandom_range(0, 5));
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    task automatic flagFail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s at cycle %0d", name, cycle);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ld_ready"}, opload_index_ready, 0);
        checkOutput({tag, "_st_ready"}, opstore_index_ready, 0);
        checkOutput({tag, "_req_valid"}, mem_req_valid, 0);
        checkOutput({tag, "_req_write"}, mem_req_write, 0);
        checkOutput({tag, "_req_index"}, mem_req_index, 0);
        checkOutput({tag, "_req_wdata"}, mem_req_wdata, 0);
        checkOutput({tag, "_req_wmask"}, mem_req_wmask, 0);
        checkOutput({tag, "_ld_done"}, opload_operation_done, 0);
        checkOutput({tag, "_st_done"}, opstore_operation_done, 0);
        checkOutput({tag, "_rdata"}, opload_read_data, 0);
        checkOutput({tag, "_bus_error"}, bus_error, 0);
    endtask

    // Reference model: what the requester should see once the request is accepted.
    task automatic predict(input req_t r, output int doneCycle);
        exp_t e;
        logic [W-1:0] old;
        e.isLoad    = !r.write;
        e.doneCycle = cycle + 3 + r.readyDelay + (r.respond ? r.respDelay : TMO - 1);
        e.rdata     = '0;
        if (!r.respond) expErr = 1'b1;
        old = refMem.exists(r.idx) ? refMem[r.idx] : defaultWord(r.idx);
        if (r.write && r.respond) refMem[r.idx] = (old & ~r.mask) | (r.wdata & r.mask);
        if (!r.write && r.respond) e.rdata = old;
        e.err = expErr;
        doneCycle = e.doneCycle;
        planQ.push_back(r);
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input req_t r);
        bit fired = 1'b0;
        int dc;
        @(posedge clock); #1;
        if (r.write) begin
            opstore_index_valid = 1'b1; opstore_index = r.idx;
            opstore_write_data = r.wdata; opstore_write_mask = r.mask;
        end else begin
            opload_index_valid = 1'b1; opload_index = r.idx;
        end
        for (int i = 0; i < 100 && !fired; i++) begin
            @(negedge clock);
            if (r.write ? opstore_index_ready : opload_index_ready) fired = 1'b1;
        end
        if (fired) predict(r, dc);
        else flagFail("accept_timeout");
        @(posedge clock); #1;
        opload_index_valid = 1'b0;
        opstore_index_valid = 1'b0;
    endtask

    task automatic applyBoth(input req_t ld, input req_t st);
        bit fired = 1'b0;
        int ldDone, stDone;
        @(posedge clock); #1;
        opload_index_valid = 1'b1; opload_index = ld.idx;
        opstore_index_valid = 1'b1; opstore_index = st.idx;
        opstore_write_data = st.wdata; opstore_write_mask = st.mask;
        for (int i = 0; i < 100 && !fired; i++) begin
            @(negedge clock);
            if (opload_index_ready) fired = 1'b1;
        end
        if (!fired) begin
            flagFail("both_load_accept_timeout");
            @(posedge clock); #1;
            opload_index_valid = 1'b0; opstore_index_valid = 1'b0;
            return;
        end
        predict(ld, ldDone);
        @(posedge clock); #1;
        opload_index_valid = 1'b0;
        fired = 1'b0;
        for (int i = 0; i < 100 && !fired; i++) begin
            @(negedge clock);
            if (opstore_index_ready) fired = 1'b1;
        end
        if (fired) begin
            checkOutput("b2b_store_accept_cycle", cycle, ldDone + 1);
            predict(st, stDone);
        end else flagFail("both_store_accept_timeout");
        @(posedge clock); #1;
        opstore_index_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 400 && (expQ.size() != 0 || respBusy); i++) @(negedge clock);
        if (expQ.size() != 0 || respBusy) begin
            flagFail("drain_timeout");
            expQ.delete();
        end
    endtask

    // Backing memory: answers requests per the plan queue, pulses stray responses when idle.
    initial begin
        req_t p;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        forever begin
            @(negedge clock);
            mem_resp_valid = 1'b0;
            if (reset_n && mem_req_valid) begin
                if (planQ.size() == 0) begin
                    flagFail("unexpected_mem_req");
                    continue;
                end
                respBusy = 1'b1;
                p = planQ.pop_front();
                for (int i = 0; i <= p.readyDelay; i++) begin
                    if (i > 0) @(negedge clock);
                    checkOutput("req_valid", mem_req_valid, 1);
                    checkOutput("req_write", mem_req_write, p.write);
                    checkOutput("req_index", mem_req_index, p.idx);
                    checkOutput("req_wdata", mem_req_wdata, p.wdata);
                    checkOutput("req_wmask", mem_req_wmask, p.mask);
                    mem_req_ready = (i == p.readyDelay);
                end
                @(negedge clock);
                mem_req_ready = 1'b0;
                if (p.respond) begin
                    repeat (p.respDelay) @(negedge clock);
                    if (mem_req_write) begin
                        bkMem[mem_req_index] =
                            ((bkMem.exists(mem_req_index) ? bkMem[mem_req_index]
                                                          : defaultWord(mem_req_index))
                             & ~mem_req_wmask) | (mem_req_wdata & mem_req_wmask);
                        mem_resp_rdata = {$urandom, $urandom};
                    end else begin
                        mem_resp_rdata = bkMem.exists(mem_req_index) ? bkMem[mem_req_index]
                                                                     : defaultWord(mem_req_index);
                    end
                    mem_resp_valid = 1'b1;
                end else begin
                    repeat (TMO) @(negedge clock);
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = {$urandom, $urandom};
                end
                respBusy = 1'b0;
            end else begin
                mem_resp_valid = reset_n && ($urandom_range(0, 7) == 0);
                mem_resp_rdata = {$urandom, $urandom};
            end
        end
    end

    // Monitor: pops one expectation per done pulse and checks held values in between.
    initial begin
        exp_t e;
        logic [W-1:0] heldRead = '0;
        bit heldErr = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                heldRead = '0;
                heldErr = 1'b0;
            end else if (opload_operation_done || opstore_operation_done) begin
                if (opload_operation_done && opstore_operation_done) flagFail("done_both");
                else if (expQ.size() == 0) flagFail("unexpected_done");
                else begin
                    e = expQ.pop_front();
                    checkOutput("done_type", opload_operation_done, e.isLoad);
                    checkOutput("done_cycle", cycle, e.doneCycle);
                    if (e.isLoad) begin
                        checkOutput("load_data", opload_read_data, e.rdata);
                        heldRead = e.rdata;
                    end else begin
                        checkOutput("store_keeps_rdata", opload_read_data, heldRead);
                    end
                    checkOutput("done_bus_error", bus_error, e.err);
                    heldErr = e.err;
                end
            end else begin
                checkOutput("rdata_hold", opload_read_data, heldRead);
                checkOutput("bus_error_hold", bus_error, heldErr);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int mode;
        refMem[64'h10] = 64'hDEADBEEF_01234567;
        bkMem[64'h10]  = 64'hDEADBEEF_01234567;

        repeat (3) @(negedge clock);
        checkAllZero("reset");
        @(posedge clock); #3;
        reset_n = 1'b1;

        applyStimulus(mkReq(1'b0, 64'h10, '0, '0, 0, 1'b1, 0));
        waitDrain();
        applyStimulus(mkReq(1'b1, 64'h20, 64'hAB00, 64'hFF00, 4, 1'b1, 1));
        waitDrain();
        applyBoth(mkReq(1'b0, 64'h20, '0, '0, 1, 1'b1, 2),
                  mkReq(1'b1, 64'h10, 64'h5555_0000_0000_00FF, 64'hFFFF_0000_0000_00FF, 0, 1'b1, 0));
        waitDrain();
        applyStimulus(mkReq(1'b0, 64'h10, '0, '0, 0, 1'b1, 0));
        applyStimulus(mkReq(1'b0, 64'h3, '0, '0, 2, 1'b0, 0));
        waitDrain();
        repeat (20) @(negedge clock);

        $display("[TB] reset during WAIT_RESP");
        applyStimulus(mkReq(1'b0, 64'h4, '0, '0, 0, 1'b0, 0));
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checkAllZero("midreset");
        expQ.delete();
        expErr = 1'b0;
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b1;
        waitDrain();
        applyStimulus(mkReq(1'b0, 64'h10, '0, '0, 1, 1'b1, 3));
        waitDrain();

        $display("[TB] random traffic");
        for (int n = 0; n < 150; n++) begin
            mode = $urandom_range(0, 19);
            if (mode < 3) applyBoth(randReq(1'b0), randReq(1'b1));
            else applyStimulus(randReq(mode[0]));
            repeat ($urandom_range(0, 3)) @(posedge clock);
        end
        waitDrain();
        repeat (10) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
